// File: rtl/svc_soc_sim_lifecycle.sv
// SoC simulation run sequencer: holds the CPU in reset, runs it under a watchdog,
// drains UART traffic after the software exit request and reports a sticky end status.
//
// state   | meaning
// HOLD    | CPU held in reset after power-on
// RUN     | CPU running; cycle counter and watchdog active
// DRAIN   | exit requested; waiting for UART TX to go idle
// DONE    | normal completion; CPU frozen
// TIMEOUT | watchdog expired; CPU frozen
module svc_soc_sim_lifecycle #(
    parameter int unsigned RESET_CYCLES      = 16,
    parameter int unsigned WATCHDOG_CYCLES   = 1_000_000,
    parameter int unsigned DRAIN_IDLE_CYCLES = 64,
    parameter int unsigned DRAIN_MAX_CYCLES  = 200_000,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             cpu_rst_n,
    input  logic             halt_req,
    input  logic [7:0]       exit_code,
    input  logic             uart_busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       final_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [31:0] HOLD_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] WD_LAST    = 32'(WATCHDOG_CYCLES - 1);
    localparam logic [31:0] IDLE_LAST  = 32'(DRAIN_IDLE_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_MAX_CYCLES - 1);
    localparam bit          WD_EN      = (WATCHDOG_CYCLES != 0);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t state, state_nxt;

    // One phase counter serves as hold timer, watchdog and drain cap; it restarts on every state change.
    logic [31:0]      phase_cnt, phase_nxt;
    logic [31:0]      idle_cnt, idle_nxt;
    logic             cpu_rst_n_nxt, done_nxt, pass_nxt, timeout_nxt;
    logic [7:0]       final_code_nxt;
    logic [CNT_W-1:0] cycle_count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HOLD;
            phase_cnt   <= '0;
            idle_cnt    <= '0;
            cpu_rst_n   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            final_code  <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            phase_cnt   <= phase_nxt;
            idle_cnt    <= idle_nxt;
            cpu_rst_n   <= cpu_rst_n_nxt;
            done        <= done_nxt;
            pass        <= pass_nxt;
            timeout     <= timeout_nxt;
            final_code  <= final_code_nxt;
            cycle_count <= cycle_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase_cnt + 32'd1;
        idle_nxt        = idle_cnt;
        cpu_rst_n_nxt   = cpu_rst_n;
        done_nxt        = done;
        pass_nxt        = pass;
        timeout_nxt     = timeout;
        final_code_nxt  = final_code;
        cycle_count_nxt = cycle_count;

        case (state)
            S_HOLD: begin
                cpu_rst_n_nxt = 1'b0;
                if (phase_cnt == HOLD_LAST) begin
                    state_nxt     = S_RUN;
                    phase_nxt     = '0;
                    cpu_rst_n_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (cycle_count != '1)
                    cycle_count_nxt = cycle_count + CNT_W'(1);
                // Exit request takes priority over a watchdog expiring in the same cycle.
                if (halt_req) begin
                    state_nxt      = S_DRAIN;
                    phase_nxt      = '0;
                    idle_nxt       = '0;
                    final_code_nxt = exit_code;
                end else if (WD_EN && (phase_cnt == WD_LAST)) begin
                    state_nxt      = S_TIMEOUT;
                    cpu_rst_n_nxt  = 1'b0;
                    done_nxt       = 1'b1;
                    pass_nxt       = 1'b0;
                    timeout_nxt    = 1'b1;
                    final_code_nxt = 8'hFF;
                end
            end
            S_DRAIN: begin
                idle_nxt = uart_busy ? '0 : idle_cnt + 32'd1;
                if ((!uart_busy && (idle_cnt == IDLE_LAST)) || (phase_cnt == DRAIN_LAST)) begin
                    state_nxt     = S_DONE;
                    cpu_rst_n_nxt = 1'b0;
                    done_nxt      = 1'b1;
                    pass_nxt      = (final_code == 8'h00);
                    timeout_nxt   = 1'b0;
                end
            end
            S_DONE, S_TIMEOUT: begin
                phase_nxt = phase_cnt;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_svc_soc_sim_lifecycle.sv
// Bench for svc_soc_sim_lifecycle: one instance for run/drain/reset scenarios,
// a second with a short watchdog and drain cap for the timeout and drain-limit cases.
module tb_svc_soc_sim_lifecycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        m_rst_n = 1'b1, m_halt = 1'b0, m_busy = 1'b0;
    logic [7:0]  m_code = 8'h00;
    logic        m_cpu_rst_n, m_done, m_pass, m_tmo;
    logic [7:0]  m_final;
    logic [31:0] m_cc;

    logic        w_rst_n = 1'b1, w_halt = 1'b0, w_busy = 1'b0;
    logic [7:0]  w_code = 8'h00;
    logic        w_cpu_rst_n, w_done, w_pass, w_tmo;
    logic [7:0]  w_final;
    logic [31:0] w_cc;

    svc_soc_sim_lifecycle #(
        .RESET_CYCLES(4), .WATCHDOG_CYCLES(1000), .DRAIN_IDLE_CYCLES(8),
        .DRAIN_MAX_CYCLES(1000), .CNT_W(32)
    ) u_main (
        .clk(clk), .rst_n(m_rst_n), .cpu_rst_n(m_cpu_rst_n), .halt_req(m_halt),
        .exit_code(m_code), .uart_busy(m_busy), .done(m_done), .pass(m_pass),
        .timeout(m_tmo), .final_code(m_final), .cycle_count(m_cc)
    );

    svc_soc_sim_lifecycle #(
        .RESET_CYCLES(4), .WATCHDOG_CYCLES(50), .DRAIN_IDLE_CYCLES(8),
        .DRAIN_MAX_CYCLES(30), .CNT_W(32)
    ) u_wd (
        .clk(clk), .rst_n(w_rst_n), .cpu_rst_n(w_cpu_rst_n), .halt_req(w_halt),
        .exit_code(w_code), .uart_busy(w_busy), .done(w_done), .pass(w_pass),
        .timeout(w_tmo), .final_code(w_final), .cycle_count(w_cc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  code;
        logic        pass;
        logic        tmo;
        logic [31:0] cc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_main();
        m_rst_n = 1'b0; m_halt = 1'b0; m_code = 8'h00; m_busy = 1'b0;
        tick(); tick();
        m_rst_n = 1'b1;
    endtask

    task automatic reset_wd();
        w_rst_n = 1'b0; w_halt = 1'b0; w_code = 8'h00; w_busy = 1'b0;
        tick(); tick();
        w_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad_hold;
        m_rst_n = 1'b0; m_halt = 1'b0; m_code = 8'h00; m_busy = 1'b0;
        tick(); tick();
        n_tests++;
        if ({m_cpu_rst_n, m_done, m_pass, m_tmo, m_final, m_cc} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cpu=%b done=%b pass=%b tmo=%b code=%h cc=%0d want all zero",
                     m_cpu_rst_n, m_done, m_pass, m_tmo, m_final, m_cc);
        end
        m_rst_n = 1'b1;
        bad_hold = 0;
        for (int e = 1; e <= 3; e++) begin
            m_halt = (e == 2 || e == 3);
            m_code = 8'h77;
            tick();
            if (m_cpu_rst_n !== 1'b0 || m_done !== 1'b0) bad_hold++;
        end
        m_halt = 1'b0;
        n_tests++;
        if (bad_hold != 0) begin
            n_fail++;
            $display("FAIL hold_cpu_rst_n: %0d early edges with cpu_rst_n/done not low, want 0", bad_hold);
        end
        tick();
        n_tests++;
        if (m_cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL release_edge4: cpu_rst_n=%b want 1", m_cpu_rst_n);
        end
        n_tests++;
        if (m_cc !== 32'd0 || m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL release_state: cc=%0d done=%b want cc=0 done=0", m_cc, m_done);
        end
        tick();
        n_tests++;
        if (m_cc !== 32'd1 || m_done !== 1'b0 || m_final !== 8'h00) begin
            n_fail++;
            $display("FAIL run_first_cycle: cc=%0d done=%b code=%h want cc=1 done=0 code=00", m_cc, m_done, m_final);
        end
    endtask

    task automatic test_halt_pass();
        int   n;
        exp_t e;
        reset_main();
        repeat (4) tick();
        repeat (99) tick();
        m_halt = 1'b1; m_code = 8'h00;
        sb.push_back('{8'h00, 1'b1, 1'b0, 32'd100, 9});
        tick();
        m_halt = 1'b0; m_code = 8'h55;
        n = 1;
        n_tests++;
        if (m_cpu_rst_n !== 1'b1 || m_done !== 1'b0 || m_cc !== 32'd100) begin
            n_fail++;
            $display("FAIL drain_entry: cpu=%b done=%b cc=%0d want cpu=1 done=0 cc=100", m_cpu_rst_n, m_done, m_cc);
        end
        while (!m_done && n < 200) begin tick(); n++; end
        e = sb.pop_front();
        n_tests++;
        if (n !== e.lat) begin n_fail++; $display("FAIL pass_latency: got %0d cycles want %0d", n, e.lat); end
        n_tests++;
        if ({m_done, m_pass, m_tmo, m_final} !== {1'b1, e.pass, e.tmo, e.code} || m_cc !== e.cc) begin
            n_fail++;
            $display("FAIL pass_flags: done=%b pass=%b tmo=%b code=%h cc=%0d want 1 %b %b %h %0d",
                     m_done, m_pass, m_tmo, m_final, m_cc, e.pass, e.tmo, e.code, e.cc);
        end
        repeat (5) tick();
        n_tests++;
        if (m_cpu_rst_n !== 1'b0 || m_done !== 1'b1 || m_cc !== 32'd100) begin
            n_fail++;
            $display("FAIL done_sticky: cpu=%b done=%b cc=%0d want cpu=0 done=1 cc=100", m_cpu_rst_n, m_done, m_cc);
        end
    endtask

    task automatic test_busy_glitch();
        int   n, k;
        exp_t e;
        reset_main();
        repeat (4) tick();
        repeat (9) tick();
        m_halt = 1'b1; m_code = 8'h2A; m_busy = 1'b1;
        sb.push_back('{8'h2A, 1'b0, 1'b0, 32'd10, 35});
        tick();
        m_halt = 1'b0;
        n = 1; k = 1;
        while (!m_done && n < 200) begin
            m_busy = (k <= 20) || (k == 26);
            m_halt = (k == 3);
            m_code = (k == 3) ? 8'h99 : 8'h2A;
            tick();
            n++; k++;
        end
        m_busy = 1'b0; m_halt = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (n !== e.lat) begin n_fail++; $display("FAIL glitch_latency: got %0d cycles want %0d", n, e.lat); end
        n_tests++;
        if ({m_done, m_pass, m_tmo, m_final} !== {1'b1, e.pass, e.tmo, e.code} || m_cc !== e.cc) begin
            n_fail++;
            $display("FAIL glitch_flags: done=%b pass=%b tmo=%b code=%h cc=%0d want 1 %b %b %h %0d",
                     m_done, m_pass, m_tmo, m_final, m_cc, e.pass, e.tmo, e.code, e.cc);
        end
    endtask

    task automatic test_timeout();
        int   n;
        exp_t e;
        reset_wd();
        repeat (4) tick();
        sb.push_back('{8'hFF, 1'b0, 1'b1, 32'd50, 50});
        n = 0;
        while (!w_done && n < 200) begin tick(); n++; end
        e = sb.pop_front();
        n_tests++;
        if (n !== e.lat) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", n, e.lat); end
        n_tests++;
        if ({w_done, w_pass, w_tmo, w_final, w_cpu_rst_n} !== {1'b1, e.pass, e.tmo, e.code, 1'b0} || w_cc !== e.cc) begin
            n_fail++;
            $display("FAIL timeout_flags: done=%b pass=%b tmo=%b code=%h cpu=%b cc=%0d want 1 %b %b %h 0 %0d",
                     w_done, w_pass, w_tmo, w_final, w_cpu_rst_n, w_cc, e.pass, e.tmo, e.code, e.cc);
        end
    endtask

    task automatic test_halt_at_expiry_and_drain_max();
        int   n;
        exp_t e;
        reset_wd();
        repeat (4) tick();
        repeat (49) tick();
        w_halt = 1'b1; w_code = 8'h00; w_busy = 1'b1;
        tick();
        w_halt = 1'b0; w_code = 8'hC3;
        n_tests++;
        if ({w_tmo, w_done, w_cpu_rst_n} !== 3'b001 || w_cc !== 32'd50) begin
            n_fail++;
            $display("FAIL halt_wins: tmo=%b done=%b cpu=%b cc=%0d want 0 0 1 50", w_tmo, w_done, w_cpu_rst_n, w_cc);
        end
        sb.push_back('{8'h00, 1'b1, 1'b0, 32'd50, 30});
        n = 0;
        repeat (5) begin tick(); n++; end
        n_tests++;
        if (w_tmo !== 1'b0 || w_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_no_watchdog: tmo=%b done=%b want 0 0", w_tmo, w_done);
        end
        while (!w_done && n < 200) begin tick(); n++; end
        e = sb.pop_front();
        n_tests++;
        if (n !== e.lat) begin n_fail++; $display("FAIL drain_max_latency: got %0d cycles want %0d", n, e.lat); end
        n_tests++;
        if ({w_done, w_pass, w_tmo, w_final, w_cpu_rst_n} !== {1'b1, e.pass, e.tmo, e.code, 1'b0} || w_cc !== e.cc) begin
            n_fail++;
            $display("FAIL drain_max_flags: done=%b pass=%b tmo=%b code=%h cpu=%b cc=%0d want 1 %b %b %h 0 %0d",
                     w_done, w_pass, w_tmo, w_final, w_cpu_rst_n, w_cc, e.pass, e.tmo, e.code, e.cc);
        end
        w_busy = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int   n, bad_hold;
        exp_t e;
        reset_main();
        repeat (4) tick();
        repeat (4) tick();
        m_halt = 1'b1; m_code = 8'h11; m_busy = 1'b1;
        tick();
        m_halt = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (m_final !== 8'h11 || m_cc !== 32'd5 || m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_latched: code=%h cc=%0d done=%b want 11 5 0", m_final, m_cc, m_done);
        end
        #2 m_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_cpu_rst_n, m_done, m_pass, m_tmo, m_final, m_cc} !== 44'h0) begin
            n_fail++;
            $display("FAIL async_reset_drain: cpu=%b done=%b code=%h cc=%0d want all zero",
                     m_cpu_rst_n, m_done, m_final, m_cc);
        end
        m_busy = 1'b0;
        tick();
        m_rst_n = 1'b1;
        bad_hold = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (m_cpu_rst_n !== 1'b0) bad_hold++;
        end
        tick();
        n_tests++;
        if (bad_hold != 0 || m_cpu_rst_n !== 1'b1 || m_cc !== 32'd0) begin
            n_fail++;
            $display("FAIL rehold_release: early=%0d cpu=%b cc=%0d want 0 1 0", bad_hold, m_cpu_rst_n, m_cc);
        end
        repeat (2) tick();
        m_halt = 1'b1; m_code = 8'h33;
        sb.push_back('{8'h33, 1'b0, 1'b0, 32'd3, 9});
        tick();
        m_halt = 1'b0;
        n = 1;
        while (!m_done && n < 200) begin tick(); n++; end
        e = sb.pop_front();
        n_tests++;
        if (n !== e.lat || {m_pass, m_tmo, m_final} !== {e.pass, e.tmo, e.code} || m_cc !== e.cc) begin
            n_fail++;
            $display("FAIL relatch: lat=%0d pass=%b tmo=%b code=%h cc=%0d want %0d %b %b %h %0d",
                     n, m_pass, m_tmo, m_final, m_cc, e.lat, e.pass, e.tmo, e.code, e.cc);
        end
        #2 m_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_cpu_rst_n, m_done, m_pass, m_tmo, m_final, m_cc} !== 44'h0) begin
            n_fail++;
            $display("FAIL async_reset_done: cpu=%b done=%b code=%h cc=%0d want all zero",
                     m_cpu_rst_n, m_done, m_final, m_cc);
        end
        tick();
        m_rst_n = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (m_cpu_rst_n !== 1'b0 || m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rehold_after_done: cpu=%b done=%b want 0 0", m_cpu_rst_n, m_done);
        end
        tick();
        n_tests++;
        if (m_cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_after_done: cpu=%b want 1", m_cpu_rst_n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running, want finished");
        $fatal(1, "time limit");
    end

    initial begin
        w_rst_n = 1'b0;
        test_reset();
        test_halt_pass();
        test_busy_glitch();
        test_timeout();
        test_halt_at_expiry_and_drain_max();
        test_reset_midrun();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/svc_soc_sim_lifecycle.md
Name: svc_soc_sim_lifecycle

Overview:
- Sequences one simulated SoC run: holds the CPU in reset after power-on, releases it, and enforces a run-cycle watchdog.
- Captures the software exit request, drains pending UART transmit traffic, then reports a sticky done/pass/timeout status.
- Sits between the testbench top and the CPU/peripheral complex inside the SoC simulation wrapper. It is the only source of the CPU reset and of the end-of-simulation flags.

Parameters:
- RESET_CYCLES, 16, cycles cpu_rst_n is held low after rst_n deasserts (≥1).
- WATCHDOG_CYCLES, 1_000_000, max cycles spent in RUN before timeout; 0 disables the watchdog.
- DRAIN_IDLE_CYCLES, 64, consecutive uart_busy=0 cycles required to finish the drain (≥1).
- DRAIN_MAX_CYCLES, 200_000, cap on cycles spent in DRAIN; when reached, the run completes anyway.
- CNT_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_rst_n  out  1  active-low reset to CPU/memories
- halt_req  in  1  single-cycle pulse: software wrote the exit MMIO register
- exit_code  in  8  exit value, valid with halt_req
- uart_busy  in  1  UART TX shift register or FIFO non-empty
- done  out  1  run finished (normal or timeout); sticky
- pass  out  1  done with exit code 0
- timeout  out  1  watchdog expired
- final_code  out  8  latched exit_code; 0xFF on timeout
- cycle_count  out  CNT_W  cycles spent in RUN; saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=HOLD, cpu_rst_n=0, done=0, pass=0, timeout=0, final_code=0, cycle_count=0.
  - All internal counters are cleared.
  - Reset asserted mid-run aborts immediately and restarts from HOLD.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- HOLD:
  - hold counter counts up from 0. While in HOLD, cpu_rst_n=0.
  - When the counter reaches RESET_CYCLES-1, go to RUN.
  - cpu_rst_n goes to 1 in the first RUN cycle, i.e. exactly RESET_CYCLES clocks after rst_n rises.
  - halt_req is ignored in HOLD.
- RUN:
  - cycle_count increments each cycle and saturates at all-ones.
  - The watchdog counter also increments each cycle.
  - halt_req=1: latch exit_code into final_code and go to DRAIN.
  - Otherwise, if WATCHDOG_CYCLES≠0 and the watchdog counter reaches WATCHDOG_CYCLES-1: go to TIMEOUT.
  - halt_req in the same cycle as watchdog expiry: halt wins.
- DRAIN:
  - cpu_rst_n stays 1 and cycle_count freezes.
  - Further halt_req pulses are ignored; the first exit_code is kept.
  - The idle counter clears whenever uart_busy=1 and increments when it is 0.
  - When idle reaches DRAIN_IDLE_CYCLES, go to DONE.
  - Independently, when the drain counter reaches DRAIN_MAX_CYCLES-1, go to DONE with the same flags.
- DONE (terminal):
  - done=1, pass=(final_code==0), timeout=0.
  - cpu_rst_n=0, so the CPU is frozen.
  - Exit only via rst_n.
- TIMEOUT (terminal):
  - done=1, timeout=1, pass=0, final_code=0xFF, cpu_rst_n=0.
  - No drain is performed.
- Flag timing:
  - done, pass, timeout and final_code are updated in the same edge as the state entry.
  - They are never all-zero → mixed transitions; pass and timeout are never both 1.
- Latency: halt_req → done is ≥DRAIN_IDLE_CYCLES+1 cycles.

Test Plan:
- Reset release, RESET_CYCLES=4 → cpu_rst_n rises on the 4th clk edge after rst_n=1; done=0; cycle_count=0 at that edge.
- halt_req with exit_code=0 at cycle 100 of RUN, uart_busy=0, DRAIN_IDLE_CYCLES=8 → done=1, pass=1, final_code=0x00 after 9 cycles; cycle_count=100 frozen; cpu_rst_n=0.
- exit_code=0x2A, uart_busy high for 20 cycles then low, with a 1-cycle busy glitch at idle=5 → idle restarts; done=1 only after 8 contiguous idle cycles; pass=0; final_code=0x2A.
- WATCHDOG_CYCLES=50, no halt → timeout=1, done=1, pass=0, final_code=0xFF after exactly 50 RUN cycles; second case: halt_req on cycle 50 → DRAIN, timeout=0.
- uart_busy stuck high, DRAIN_MAX_CYCLES=30 → done=1 exactly 30 cycles after DRAIN entry.
- rst_n pulsed low during DRAIN and during DONE → all outputs zero asynchronously; full HOLD→RUN sequence repeats; second halt_req with a different code is latched fresh.
